// File: rtl/joystick_pkg.sv
// rtl/joystick_pkg.sv - shared types and XADC constants for the joystick axis sampler
// Ports: none (package).

package joystick_pkg;

  // XADC DRP status-register addresses of the auxiliary analog inputs.
  localparam logic [6:0] XADC_ADDR_VAUX6 = 7'h16;
  localparam logic [6:0] XADC_ADDR_VAUX7 = 7'h17;

  // XADC results are 12-bit, left-justified in the 16-bit DRP word.
  localparam int SAMPLE_W   = 12;
  localparam int SAMPLE_MAX = (1 << SAMPLE_W) - 1;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_X  = 3'd1,
    ST_WAIT_X = 3'd2,
    ST_REQ_Y  = 3'd3,
    ST_WAIT_Y = 3'd4,
    ST_UPDATE = 3'd5
  } state_t;

  // Clamp a threshold expression into the representable sample range.
  function automatic int sat_sample(input int v);
    if (v < 0) begin
      return 0;
    end else if (v > SAMPLE_MAX) begin
      return SAMPLE_MAX;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/axis_classifier.sv
// rtl/axis_classifier.sv - per-axis window accumulator, mean and dead-zone/hysteresis classifier
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_sample [11:0]  raw sample, added to the accumulator on i_sample_stb
//   i_sample_stb     one-cycle strobe: accumulate i_sample
//   i_update_stb     one-cycle strobe: publish mean, reclassify, clear accumulator
//   o_dir [1:0]      registered direction code (dir_t)
//   o_avg [11:0]     registered mean of the last completed window

module axis_classifier
  import joystick_pkg::*;
#(
  parameter int CENTER    = 2048,
  parameter int DEAD_ZONE = 512,
  parameter int HYST      = 128,
  parameter int AVG_LOG2  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_stb,
  input  logic                i_update_stb,
  output logic [1:0]          o_dir,
  output logic [SAMPLE_W-1:0] o_avg
);

  // Wide enough for 2^AVG_LOG2 full-scale samples, so the sum never wraps.
  localparam int ACC_W = SAMPLE_W + AVG_LOG2;

  localparam int POS_ENTER_I = sat_sample(CENTER + DEAD_ZONE);
  localparam int NEG_ENTER_I = sat_sample(CENTER - DEAD_ZONE);

  localparam logic [SAMPLE_W-1:0] POS_ENTER = SAMPLE_W'(POS_ENTER_I);
  localparam logic [SAMPLE_W-1:0] POS_EXIT  = SAMPLE_W'(sat_sample(POS_ENTER_I - HYST));
  localparam logic [SAMPLE_W-1:0] NEG_ENTER = SAMPLE_W'(NEG_ENTER_I);
  localparam logic [SAMPLE_W-1:0] NEG_EXIT  = SAMPLE_W'(sat_sample(NEG_ENTER_I + HYST));

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_W-1:0] avg_q, avg_d;
  dir_t                dir_q, dir_d;

  logic [SAMPLE_W-1:0] mean;
  dir_t                fresh_dir;

  always_comb begin
    // Dropping the low AVG_LOG2 bits is the divide by the window length.
    mean = acc_q[ACC_W-1:AVG_LOG2];

    // Classification as seen from the neutral state; also the fallback
    // whenever a deflected axis drops inside its exit threshold.
    if (mean >= POS_ENTER) begin
      fresh_dir = DIR_POS;
    end else if (mean <= NEG_ENTER) begin
      fresh_dir = DIR_NEG;
    end else begin
      fresh_dir = DIR_NONE;
    end

    acc_d = acc_q;
    avg_d = avg_q;
    dir_d = dir_q;

    if (i_update_stb) begin
      avg_d = mean;
      acc_d = '0;
      case (dir_q)
        DIR_POS: dir_d = (mean > POS_EXIT) ? DIR_POS : fresh_dir;
        DIR_NEG: dir_d = (mean < NEG_EXIT) ? DIR_NEG : fresh_dir;
        default: dir_d = fresh_dir;
      endcase
    end else if (i_sample_stb) begin
      acc_d = acc_q + ACC_W'(i_sample);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      avg_q <= '0;
      dir_q <= DIR_NONE;
    end else begin
      acc_q <= acc_d;
      avg_q <= avg_d;
      dir_q <= dir_d;
    end
  end

  assign o_dir = dir_q;
  assign o_avg = avg_q;

endmodule

// File: rtl/joystick_axis_sampler.sv
// rtl/joystick_axis_sampler.sv - XADC DRP reader that averages and classifies joystick X/Y axes
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_eoc                 XADC end-of-conversion pulse, starts one X/Y read pair
//   o_den, o_daddr [6:0]  DRP read request (one-cycle enable) and address
//   i_drdy, i_do [15:0]   DRP read completion and data (sample in i_do[15:4])
//   o_x_dir, o_y_dir      direction codes: 0 none, 1 positive, 2 negative
//   o_x_avg, o_y_avg      averaged raw values of the last window
//   o_valid               one-cycle pulse when dir/avg outputs update
//   o_timeout_err         sticky flag: a DRP read never completed

module joystick_axis_sampler
  import joystick_pkg::*;
#(
  parameter logic [6:0] ADDR_X         = XADC_ADDR_VAUX6,
  parameter logic [6:0] ADDR_Y         = XADC_ADDR_VAUX7,
  parameter int         CENTER         = 2048,
  parameter int         DEAD_ZONE      = 512,
  parameter int         HYST           = 128,
  parameter int         AVG_LOG2       = 2,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_eoc,
  output logic                o_den,
  output logic [6:0]          o_daddr,
  input  logic                i_drdy,
  input  logic [15:0]         i_do,
  output logic [1:0]          o_x_dir,
  output logic [1:0]          o_y_dir,
  output logic [SAMPLE_W-1:0] o_x_avg,
  output logic [SAMPLE_W-1:0] o_y_avg,
  output logic                o_valid,
  output logic                o_timeout_err
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PAIR_W = AVG_LOG2 + 1;

  // Value of the wait counter during the last permitted wait cycle.
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PAIR_W-1:0] PAIRS    = PAIR_W'(1 << AVG_LOG2);

  state_t              state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [PAIR_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [SAMPLE_W-1:0] x_hold_q, x_hold_d;
  logic                timeout_err_q, timeout_err_d;
  logic                valid_q, valid_d;

  logic                sample_stb;
  logic                update_stb;
  logic [SAMPLE_W-1:0] drp_sample;
  logic                unused_do_lsbs;

  assign drp_sample     = i_do[15:4];
  assign unused_do_lsbs = &{1'b0, i_do[3:0]};

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    pair_cnt_d    = pair_cnt_q;
    x_hold_d      = x_hold_q;
    timeout_err_d = timeout_err_q;
    o_den         = 1'b0;
    o_daddr       = ADDR_X;
    sample_stb    = 1'b0;
    update_stb    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_eoc) begin
          state_d = ST_REQ_X;
        end
      end

      ST_REQ_X: begin
        o_den   = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT_X;
      end

      // i_drdy wins over expiry, so a completion in the final cycle counts.
      ST_WAIT_X: begin
        if (i_drdy) begin
          x_hold_d = drp_sample;
          state_d  = ST_REQ_Y;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_REQ_Y: begin
        o_den   = 1'b1;
        o_daddr = ADDR_Y;
        tmo_d   = '0;
        state_d = ST_WAIT_Y;
      end

      // The pair is committed only here, so a timeout on either read
      // leaves the accumulators and pair count untouched.
      ST_WAIT_Y: begin
        o_daddr = ADDR_Y;
        if (i_drdy) begin
          sample_stb = 1'b1;
          pair_cnt_d = pair_cnt_q + 1'b1;
          state_d    = (pair_cnt_d == PAIRS) ? ST_UPDATE : ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_UPDATE: begin
        update_stb = 1'b1;
        pair_cnt_d = '0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Classifier outputs register on the same edge, so the strobe lines up.
    valid_d = update_stb;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      tmo_q         <= '0;
      pair_cnt_q    <= '0;
      x_hold_q      <= '0;
      timeout_err_q <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      pair_cnt_q    <= pair_cnt_d;
      x_hold_q      <= x_hold_d;
      timeout_err_q <= timeout_err_d;
      valid_q       <= valid_d;
    end
  end

  axis_classifier #(
    .CENTER    (CENTER),
    .DEAD_ZONE (DEAD_ZONE),
    .HYST      (HYST),
    .AVG_LOG2  (AVG_LOG2)
  ) u_x_axis (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_sample     (x_hold_q),
    .i_sample_stb (sample_stb),
    .i_update_stb (update_stb),
    .o_dir        (o_x_dir),
    .o_avg        (o_x_avg)
  );

  axis_classifier #(
    .CENTER    (CENTER),
    .DEAD_ZONE (DEAD_ZONE),
    .HYST      (HYST),
    .AVG_LOG2  (AVG_LOG2)
  ) u_y_axis (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_sample     (drp_sample),
    .i_sample_stb (sample_stb),
    .i_update_stb (update_stb),
    .o_dir        (o_y_dir),
    .o_avg        (o_y_avg)
  );

  assign o_valid       = valid_q;
  assign o_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_joystick_axis_sampler.sv
// tb/tb_joystick_axis_sampler.sv - directed self-checking bench for joystick_axis_sampler

module tb_joystick_axis_sampler;

  localparam logic [6:0] AX = 7'h16;
  localparam logic [6:0] AY = 7'h17;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_eoc = 1'b0;
  logic        i_drdy = 1'b0;
  logic [15:0] i_do = 16'h0;
  logic        o_den;
  logic [6:0]  o_daddr;
  logic [1:0]  o_x_dir;
  logic [1:0]  o_y_dir;
  logic [11:0] o_x_avg;
  logic [11:0] o_y_avg;
  logic        o_valid;
  logic        o_timeout_err;

  int   n_cmp = 0;
  int   n_err = 0;
  logic noise_eoc = 1'b0;

  always #5 i_clk = ~i_clk;

  joystick_axis_sampler dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_eoc         (i_eoc),
    .o_den         (o_den),
    .o_daddr       (o_daddr),
    .i_drdy        (i_drdy),
    .i_do          (i_do),
    .o_x_dir       (o_x_dir),
    .o_y_dir       (o_y_dir),
    .o_x_avg       (o_x_avg),
    .o_y_avg       (o_y_avg),
    .o_valid       (o_valid),
    .o_timeout_err (o_timeout_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input logic [1:0] xd, input logic [1:0] yd,
                          input logic [11:0] xa, input logic [11:0] ya);
    chk("x_dir", o_x_dir, xd);
    chk("y_dir", o_y_dir, yd);
    chk("x_avg", o_x_avg, xa);
    chk("y_avg", o_y_avg, ya);
  endtask

  // Entered at the negedge where o_den is expected (or about to be) high;
  // returns at the negedge after the i_drdy cycle.
  task automatic drp_read(input logic [6:0] addr, input logic [11:0] val, input int lat);
    int n = 0;
    while (o_den !== 1'b1 && n < 8) begin
      @(negedge i_clk);
      n++;
    end
    chk("den_seen", o_den, 1);
    chk("daddr_at_den", o_daddr, addr);
    for (int i = 1; i < lat; i++) begin
      @(negedge i_clk);
      i_eoc = noise_eoc && (i == 2);
      chk("den_one_cycle", o_den, 0);
      chk("daddr_stable", o_daddr, addr);
    end
    @(negedge i_clk);
    i_eoc  = 1'b0;
    i_drdy = 1'b1;
    i_do   = {val, 4'h0};
    chk("daddr_at_drdy", o_daddr, addr);
    @(negedge i_clk);
    i_drdy = 1'b0;
    i_do   = 16'h0;
  endtask

  task automatic do_pair(input logic [11:0] x, input logic [11:0] y,
                         input logic exp_valid, input int lat);
    @(negedge i_clk);
    i_eoc = 1'b1;
    @(negedge i_clk);
    i_eoc = 1'b0;
    drp_read(AX, x, lat);
    drp_read(AY, y, lat);
    chk("valid_early", o_valid, 0);
    @(negedge i_clk);
    chk("valid", o_valid, exp_valid);
    if (exp_valid) begin
      @(negedge i_clk);
      chk("valid_pulse", o_valid, 0);
    end
  endtask

  task automatic do_window(input logic [11:0] x, input logic [11:0] y, input int lat);
    for (int p = 0; p < 4; p++) begin
      do_pair(x, y, p == 3, lat);
    end
  endtask

  initial begin
    // Power-on reset state.
    repeat (2) @(negedge i_clk);
    chk("rst_den", o_den, 0);
    chk("rst_daddr", o_daddr, AX);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_timeout_err, 0);
    chk_outs(0, 0, 0, 0);
    i_rst_n = 1'b1;

    // X pushed positive, Y pushed negative.
    do_window(12'd2600, 12'd1000, 5);
    chk_outs(1, 2, 12'd2600, 12'd1000);

    // Reset during WAIT_Y with two and a half pairs accumulated.
    do_pair(12'd2600, 12'd1000, 0, 5);
    do_pair(12'd2600, 12'd1000, 0, 5);
    @(negedge i_clk);
    i_eoc = 1'b1;
    @(negedge i_clk);
    i_eoc = 1'b0;
    drp_read(AX, 12'd2600, 5);
    @(negedge i_clk);
    chk("wait_y_daddr", o_daddr, AY);
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_den", o_den, 0);
    chk("arst_daddr", o_daddr, AX);
    chk("arst_valid", o_valid, 0);
    chk("arst_err", o_timeout_err, 0);
    chk_outs(0, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Centre: four fresh pairs needed after reset.
    do_window(12'd2048, 12'd2048, 5);
    chk_outs(0, 0, 12'd2048, 12'd2048);

    // Hysteresis on X.
    do_window(12'd2600, 12'd2048, 5);
    chk_outs(1, 0, 12'd2600, 12'd2048);
    do_window(12'd2500, 12'd2048, 5);
    chk_outs(1, 0, 12'd2500, 12'd2048);
    do_window(12'd2400, 12'd2048, 5);
    chk_outs(0, 0, 12'd2400, 12'd2048);
    do_window(12'd1500, 12'd2048, 5);
    chk_outs(2, 0, 12'd1500, 12'd2048);

    // Averaging on Y; X leaves NEG back to NONE.
    do_pair(12'd2048, 12'd3000, 0, 5);
    do_pair(12'd2048, 12'd3000, 0, 5);
    do_pair(12'd2048, 12'd1000, 0, 5);
    do_pair(12'd2048, 12'd1000, 1, 5);
    chk_outs(0, 0, 12'd2048, 12'd2000);

    // Stray i_drdy in IDLE and i_eoc pulses inside WAIT states.
    noise_eoc = 1'b1;
    do_pair(12'd1600, 12'd2300, 0, 5);
    do_pair(12'd1600, 12'd2300, 0, 5);
    @(negedge i_clk);
    i_drdy = 1'b1;
    i_do   = 16'hFFF0;
    @(negedge i_clk);
    i_drdy = 1'b0;
    i_do   = 16'h0;
    chk("stray_den", o_den, 0);
    do_pair(12'd1600, 12'd2300, 0, 5);
    do_pair(12'd1600, 12'd2300, 1, 5);
    noise_eoc = 1'b0;
    chk_outs(0, 0, 12'd1600, 12'd2300);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("no_queued_eoc", o_den, 0);
    end

    // i_drdy in the 64th wait cycle is a normal completion.
    do_pair(12'd3000, 12'd2048, 0, 64);
    chk("edge_no_err", o_timeout_err, 0);
    do_pair(12'd3000, 12'd2048, 0, 5);
    do_pair(12'd3000, 12'd2048, 0, 5);
    do_pair(12'd3000, 12'd2048, 1, 5);
    chk_outs(1, 0, 12'd3000, 12'd2048);
    chk("edge_err_clear", o_timeout_err, 0);

    // Timeout in WAIT_X.
    @(negedge i_clk);
    i_eoc = 1'b1;
    @(negedge i_clk);
    i_eoc = 1'b0;
    chk("tmo_den", o_den, 1);
    for (int i = 1; i <= 64; i++) begin
      @(negedge i_clk);
      chk("tmo_err_pending", o_timeout_err, 0);
    end
    @(negedge i_clk);
    chk("tmo_err_set", o_timeout_err, 1);
    chk("tmo_den_idle", o_den, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("tmo_den_silent", o_den, 0);
    end

    // The timed-out pair did not count: four more pairs for one update.
    do_window(12'd1000, 12'd2048, 5);
    chk_outs(2, 0, 12'd1000, 12'd2048);
    chk("tmo_err_sticky", o_timeout_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
